// File: rtl/ccw_fifo.sv
// ccw_fifo: byte FIFO with a registered first-word-fall-through head, feeding the HSI master.
//   clk, rst            : clock and synchronous active-high reset
//   wr_en, d            : write strobe and byte
//   full, afull         : occupancy == DEPTH, occupancy >= AF_LEVEL
//   rd_en, q, rdy       : pop strobe, head byte, head valid
//   flush               : discard all contents
//   count               : stored bytes including the byte on q
//   ovf, unf, clr_err   : sticky overflow/underflow flags and their clear
module ccw_fifo #(
   parameter int DEPTH    = 16,
   parameter int AF_LEVEL = 12
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_en,
   input  logic [7:0]               d,
   output logic                     full,
   output logic                     afull,
   input  logic                     rd_en,
   output logic [7:0]               q,
   output logic                     rdy,
   input  logic                     flush,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     ovf,
   output logic                     unf,
   input  logic                     clr_err
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   typedef enum logic [1:0] {EMPTY, VALID, FULL} state_t;
   state_t            state;
   logic [7:0]        mem [DEPTH];
   logic [AW-1:0]     wptr, rptr;
   logic              pop, wr_ok, load, rdy_nxt;
   logic [CW-1:0]     count_nxt;
   assign rdy  = state != EMPTY;
   assign full = state == FULL;
   // The array holds every stored byte except the one already copied to q,
   // so the head is refilled whenever q is empty or being popped.
   always_comb begin
      pop       = rd_en & rdy;
      wr_ok     = wr_en & (~full | pop);
      load      = (count != CW'(rdy)) & (~rdy | pop);
      rdy_nxt   = load | (rdy & ~pop);
      count_nxt = count + CW'(wr_ok) - CW'(pop);
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= EMPTY;
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
         afull <= 1'b0;
         q     <= 8'h00;
         ovf   <= 1'b0;
         unf   <= 1'b0;
      end else if (flush) begin
         state <= EMPTY;
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
         afull <= 1'b0;
         ovf   <= ovf & ~clr_err;
         unf   <= unf & ~clr_err;
      end else begin
         if (wr_ok) wptr <= wptr + 1'b1;
         if (load) begin
            q    <= mem[rptr];
            rptr <= rptr + 1'b1;
         end
         count <= count_nxt;
         afull <= count_nxt >= CW'(AF_LEVEL);
         state <= !rdy_nxt ? EMPTY : (count_nxt == CW'(DEPTH)) ? FULL : VALID;
         ovf   <= (ovf & ~clr_err) | (wr_en & full & ~pop);
         unf   <= (unf & ~clr_err) | (rd_en & ~rdy);
      end
   end
   always_ff @(posedge clk) begin
      if (!rst && !flush && wr_ok) mem[wptr] <= d;
   end
endmodule

// File: tb/tb_ccw_fifo.sv
// tb_ccw_fifo: directed self-checking bench for ccw_fifo (DEPTH=16, AF_LEVEL=12).
module tb_ccw_fifo;
   logic       clk = 1'b0;
   logic       rst, wr_en, rd_en, flush, clr_err;
   logic [7:0] d, q;
   logic       full, afull, rdy, ovf, unf;
   logic [4:0] count;
   int         total = 0;
   int         passed = 0;

   ccw_fifo #(.DEPTH(16), .AF_LEVEL(12)) dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .d(d), .full(full), .afull(afull),
      .rd_en(rd_en), .q(q), .rdy(rdy), .flush(flush), .count(count),
      .ovf(ovf), .unf(unf), .clr_err(clr_err)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle;
      wr_en = 0; rd_en = 0; flush = 0; clr_err = 0; rst = 0; d = 8'h00;
   endtask

   task automatic test_reset;
      idle(); rst = 1; tick(); rst = 0;
      total++; if (count !== 5'd0) $display("FAIL reset_count got %0d want 0", count); else passed++;
      total++; if (rdy !== 1'b0) $display("FAIL reset_rdy got %b want 0", rdy); else passed++;
      total++; if (q !== 8'h00) $display("FAIL reset_q got %h want 00", q); else passed++;
      total++; if ({full, afull, ovf, unf} !== 4'b0000) $display("FAIL reset_flags got %b want 0000", {full, afull, ovf, unf}); else passed++;
   endtask

   task automatic test_single;
      wr_en = 1; d = 8'hA5; tick(); idle();
      total++; if ({rdy, count} !== {1'b0, 5'd1}) $display("FAIL single_bubble got rdy=%b count=%0d want rdy=0 count=1", rdy, count); else passed++;
      tick();
      total++; if ({rdy, q, count} !== {1'b1, 8'hA5, 5'd1}) $display("FAIL single_head got rdy=%b q=%h count=%0d want 1 a5 1", rdy, q, count); else passed++;
      rd_en = 1; tick(); idle();
      total++; if ({rdy, count, unf} !== {1'b0, 5'd0, 1'b0}) $display("FAIL single_pop got rdy=%b count=%0d unf=%b want 0 0 0", rdy, count, unf); else passed++;
   endtask

   task automatic test_fill;
      for (int i = 0; i < 16; i++) begin
         wr_en = 1; d = 8'(i); tick();
         total++;
         if ({count, afull, full} !== {5'(i + 1), (i + 1 >= 12), (i + 1 == 16)})
            $display("FAIL fill_%0d got count=%0d afull=%b full=%b want %0d %b %b", i, count, afull, full, i + 1, i + 1 >= 12, i + 1 == 16);
         else passed++;
      end
      d = 8'hFF; tick(); idle();
      total++; if ({ovf, full, count} !== {1'b1, 1'b1, 5'd16}) $display("FAIL overflow got ovf=%b full=%b count=%0d want 1 1 16", ovf, full, count); else passed++;
      for (int i = 0; i < 16; i++) begin
         total++; if ({rdy, q} !== {1'b1, 8'(i)}) $display("FAIL drain_%0d got rdy=%b q=%h want 1 %h", i, rdy, q, 8'(i)); else passed++;
         rd_en = 1; tick();
      end
      idle();
      total++; if ({rdy, count, full, afull} !== {1'b0, 5'd0, 1'b0, 1'b0}) $display("FAIL drained got rdy=%b count=%0d full=%b afull=%b want 0 0 0 0", rdy, count, full, afull); else passed++;
      clr_err = 1; tick(); idle();
      total++; if (ovf !== 1'b0) $display("FAIL clr_ovf got %b want 0", ovf); else passed++;
   endtask

   task automatic test_back_to_back;
      for (int i = 0; i < 5; i++) begin
         wr_en = 1; d = 8'(8'h10 + i); tick();
      end
      idle(); tick();
      total++; if ({count, rdy, q} !== {5'd5, 1'b1, 8'h10}) $display("FAIL b2b_start got count=%0d rdy=%b q=%h want 5 1 10", count, rdy, q); else passed++;
      for (int i = 0; i < 40; i++) begin
         wr_en = 1; rd_en = 1; d = 8'(8'h15 + i); tick();
         total++;
         if ({count, rdy, q} !== {5'd5, 1'b1, 8'(8'h11 + i)})
            $display("FAIL b2b_%0d got count=%0d rdy=%b q=%h want 5 1 %h", i, count, rdy, q, 8'(8'h11 + i));
         else passed++;
      end
      idle();
      for (int i = 0; i < 5; i++) begin
         total++; if ({rdy, q} !== {1'b1, 8'(8'h38 + i)}) $display("FAIL b2b_drain_%0d got rdy=%b q=%h want 1 %h", i, rdy, q, 8'(8'h38 + i)); else passed++;
         rd_en = 1; tick();
      end
      idle();
      total++; if ({count, rdy, unf} !== {5'd0, 1'b0, 1'b0}) $display("FAIL b2b_end got count=%0d rdy=%b unf=%b want 0 0 0", count, rdy, unf); else passed++;
   endtask

   task automatic test_underflow;
      rd_en = 1; tick(); idle();
      total++; if ({unf, q, count, rdy} !== {1'b1, 8'h3C, 5'd0, 1'b0}) $display("FAIL unf_set got unf=%b q=%h count=%0d rdy=%b want 1 3c 0 0", unf, q, count, rdy); else passed++;
      rd_en = 1; clr_err = 1; tick(); idle();
      total++; if (unf !== 1'b1) $display("FAIL unf_set_wins got %b want 1", unf); else passed++;
      clr_err = 1; tick(); idle();
      total++; if (unf !== 1'b0) $display("FAIL unf_clear got %b want 0", unf); else passed++;
   endtask

   task automatic test_flush;
      rd_en = 1; tick(); idle();
      for (int i = 0; i < 7; i++) begin
         wr_en = 1; d = 8'(8'h40 + i); tick();
      end
      idle(); tick();
      total++; if ({count, q} !== {5'd7, 8'h40}) $display("FAIL flush_pre got count=%0d q=%h want 7 40", count, q); else passed++;
      flush = 1; wr_en = 1; d = 8'h99; tick(); idle();
      total++; if ({count, rdy, q, unf} !== {5'd0, 1'b0, 8'h40, 1'b1}) $display("FAIL flush got count=%0d rdy=%b q=%h unf=%b want 0 0 40 1", count, rdy, q, unf); else passed++;
      tick();
      total++; if ({count, rdy} !== {5'd0, 1'b0}) $display("FAIL flush_ignored_wr got count=%0d rdy=%b want 0 0", count, rdy); else passed++;
      for (int i = 0; i < 7; i++) begin
         wr_en = 1; d = 8'(8'h50 + i); tick();
      end
      idle(); tick();
      rst = 1; wr_en = 1; d = 8'h99; tick();
      rst = 0; d = 8'h77; tick(); idle();
      total++; if ({count, rdy, q, unf, ovf} !== {5'd1, 1'b0, 8'h00, 1'b0, 1'b0}) $display("FAIL rst_midop got count=%0d rdy=%b q=%h unf=%b ovf=%b want 1 0 00 0 0", count, rdy, q, unf, ovf); else passed++;
      tick();
      total++; if ({rdy, q} !== {1'b1, 8'h77}) $display("FAIL rst_first_wr got rdy=%b q=%h want 1 77", rdy, q); else passed++;
   endtask

   task automatic test_full_pass;
      for (int i = 0; i < 15; i++) begin
         wr_en = 1; d = 8'(8'h78 + i); tick();
      end
      idle();
      total++; if ({full, count} !== {1'b1, 5'd16}) $display("FAIL full_again got full=%b count=%0d want 1 16", full, count); else passed++;
      wr_en = 1; rd_en = 1; d = 8'hAA; tick(); idle();
      total++; if ({full, count, ovf, q} !== {1'b1, 5'd16, 1'b0, 8'h78}) $display("FAIL full_wr_pop got full=%b count=%0d ovf=%b q=%h want 1 16 0 78", full, count, ovf, q); else passed++;
   endtask

   initial begin
      idle();
      test_reset();
      test_single();
      test_fill();
      test_back_to_back();
      test_underflow();
      test_flush();
      test_full_pass();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
